// File: rtl/conv_pkg.sv
// Shared definitions for the convolution datapath: FSM encoding and default widths.
package conv_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_ACC_WIDTH   = 24;
    localparam int DEF_OUT_WIDTH   = 16;
    localparam int DEF_KERNEL_TAPS = 9;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ACCUM = ST_ACCUM,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } conv_state_e;

endpackage

// File: rtl/conv_sat_shift.sv
// Combinational fixed-point scaler: arithmetic shift, clamp to OUT_WIDTH, optional ReLU.
// Optional ReLU is enabled by defining CONV_MAC_ACC_RELU_EN.
module conv_sat_shift #(
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 0
) (
    input  logic signed [ACC_WIDTH-1:0] acc_in,
    output logic signed [OUT_WIDTH-1:0] res_out
);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    function automatic logic signed [OUT_WIDTH-1:0] sat(input logic signed [ACC_WIDTH-1:0] v);
        logic signed [OUT_WIDTH-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[OUT_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            r = v[OUT_WIDTH-1:0];
        end
        return r;
    endfunction

    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [OUT_WIDTH-1:0] clamped;

    assign shifted = acc_in >>> FRAC_BITS;
    assign clamped = sat(shifted);

`ifdef CONV_MAC_ACC_RELU_EN
    assign res_out = clamped[OUT_WIDTH-1] ? '0 : clamped;
`else
    assign res_out = clamped;
`endif

endmodule

// File: rtl/conv_mac_acc.sv
// Windowed multiply-accumulate feeding the output register; Result_Valid drives its Set.
// Optional ReLU on the result is enabled by defining CONV_MAC_ACC_RELU_EN.
module conv_mac_acc
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int KERNEL_TAPS = DEF_KERNEL_TAPS,
    parameter int FRAC_BITS   = 0
) (
    input  logic                         CONV_MAC_ACC_Clk,
    input  logic                         CONV_MAC_ACC_Reset,
    input  logic                         CONV_MAC_ACC_Start,
    input  logic                         CONV_MAC_ACC_Valid_In,
    input  logic signed [DATA_WIDTH-1:0] CONV_MAC_ACC_Pixel_In,
    input  logic signed [DATA_WIDTH-1:0] CONV_MAC_ACC_Weight_In,
    output logic                         CONV_MAC_ACC_Busy,
    output logic signed [OUT_WIDTH-1:0]  CONV_MAC_ACC_Result,
    output logic                         CONV_MAC_ACC_Result_Valid
);

    localparam int CNT_W = (KERNEL_TAPS > 1) ? $clog2(KERNEL_TAPS) + 1 : 1;
    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(KERNEL_TAPS - 1);

    conv_state_e                   state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [2*DATA_WIDTH-1:0] prod_q, prod_d;
    logic                          pvld_q, pvld_d;
    logic signed [OUT_WIDTH-1:0]   result_q, result_d;
    logic                          rvld_q, rvld_d;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [OUT_WIDTH-1:0]   sat_res;

    assign prod_ext = {{(ACC_WIDTH-2*DATA_WIDTH){prod_q[2*DATA_WIDTH-1]}}, prod_q};

    conv_sat_shift #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_sat (
        .acc_in  (acc_q),
        .res_out (sat_res)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        pvld_d   = 1'b0;
        result_d = result_q;
        rvld_d   = 1'b0;

        if (pvld_q) begin
            acc_d = acc_q + prod_ext;
        end

        case (state_q)
            IDLE: begin
                if (CONV_MAC_ACC_Start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            ACCUM: begin
                // A restart drops the in-flight product as well as the partial sum.
                if (CONV_MAC_ACC_Start) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (CONV_MAC_ACC_Valid_In) begin
                    prod_d = CONV_MAC_ACC_Pixel_In * CONV_MAC_ACC_Weight_In;
                    pvld_d = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_TAP) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (CONV_MAC_ACC_Start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                result_d = sat_res;
                rvld_d   = 1'b1;
                if (CONV_MAC_ACC_Start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CONV_MAC_ACC_Clk or negedge CONV_MAC_ACC_Reset) begin
        if (!CONV_MAC_ACC_Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            pvld_q   <= 1'b0;
            result_q <= '0;
            rvld_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            pvld_q   <= pvld_d;
            result_q <= result_d;
            rvld_q   <= rvld_d;
        end
    end

    assign CONV_MAC_ACC_Busy         = (state_q != IDLE);
    assign CONV_MAC_ACC_Result       = result_q;
    assign CONV_MAC_ACC_Result_Valid = rvld_q;

endmodule

// File: tb/tb_conv_mac_acc.sv
// Directed/random bench for conv_mac_acc: default instance plus a FRAC_BITS=4 instance on shared stimulus.
module tb_conv_mac_acc;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              valid = 1'b0;
    logic signed [7:0] pix = '0;
    logic signed [7:0] wt = '0;

    logic              busy0, rvld0, busy4, rvld4;
    logic signed [15:0] res0, res4;

    int total = 0;
    int bad = 0;
    int rv0_cnt = 0;
    int rv4_cnt = 0;
    int pix_a[9];
    int wt_a[9];

    always #5 clk = ~clk;

    conv_mac_acc u_dut0 (
        .CONV_MAC_ACC_Clk          (clk),
        .CONV_MAC_ACC_Reset        (rst_n),
        .CONV_MAC_ACC_Start        (start),
        .CONV_MAC_ACC_Valid_In     (valid),
        .CONV_MAC_ACC_Pixel_In     (pix),
        .CONV_MAC_ACC_Weight_In    (wt),
        .CONV_MAC_ACC_Busy         (busy0),
        .CONV_MAC_ACC_Result       (res0),
        .CONV_MAC_ACC_Result_Valid (rvld0)
    );

    conv_mac_acc #(.FRAC_BITS(4)) u_dut4 (
        .CONV_MAC_ACC_Clk          (clk),
        .CONV_MAC_ACC_Reset        (rst_n),
        .CONV_MAC_ACC_Start        (start),
        .CONV_MAC_ACC_Valid_In     (valid),
        .CONV_MAC_ACC_Pixel_In     (pix),
        .CONV_MAC_ACC_Weight_In    (wt),
        .CONV_MAC_ACC_Busy         (busy4),
        .CONV_MAC_ACC_Result       (res4),
        .CONV_MAC_ACC_Result_Valid (rvld4)
    );

    always @(posedge clk) begin
        if (rvld0) rv0_cnt <= rv0_cnt + 1;
        if (rvld4) rv4_cnt <= rv4_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference: full-precision sum, arithmetic shift, clamp to 16 bits, optional ReLU.
    function automatic longint ref_out(input longint sum, input int frac);
        longint s;
        s = sum >>> frac;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef CONV_MAC_ACC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        pix = 8'($urandom_range(0, 255));
        wt  = 8'($urandom_range(0, 255));
    endtask

    task automatic fill(input int p, input int w);
        for (int i = 0; i < 9; i++) begin
            pix_a[i] = p;
            wt_a[i]  = w;
        end
    endtask

    task automatic open_window();
        valid = 1'b1;
        noise();
        tick();
        start = 1'b1;
        noise();
        tick();
        start = 1'b0;
        valid = 1'b0;
    endtask

    task automatic feed(input int n, input int gmax);
        for (int i = 0; i < n; i++) begin
            int gaps;
            gaps = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
            for (int g = 0; g < gaps; g++) begin
                valid = 1'b0;
                noise();
                tick();
            end
            valid = 1'b1;
            pix = 8'(pix_a[i]);
            wt  = 8'(wt_a[i]);
            tick();
        end
        valid = 1'b0;
        noise();
    endtask

    task automatic finish_window(input string tag, input longint sum, input int base0, input int base4);
        longint e0, e4;
        e0 = ref_out(sum, 0);
        e4 = ref_out(sum, 4);
        chk({tag, "_rvld_k"}, 64'(rvld0), 64'(0));
        chk({tag, "_busy_k"}, 64'(busy0), 64'(1));
        tick();
        chk({tag, "_rvld_k1"}, 64'(rvld0), 64'(0));
        tick();
        chk({tag, "_rvld_k2"}, 64'(rvld0), 64'(1));
        chk({tag, "_rvld4_k2"}, 64'(rvld4), 64'(1));
        chk({tag, "_res0"}, 64'(res0), e0);
        chk({tag, "_res4"}, 64'(res4), e4);
        chk({tag, "_busy_after"}, 64'(busy0), 64'(0));
        tick();
        chk({tag, "_rvld_k3"}, 64'(rvld0), 64'(0));
        chk({tag, "_res0_hold"}, 64'(res0), e0);
        chk({tag, "_pulses0"}, 64'(rv0_cnt - base0), 64'(1));
        chk({tag, "_pulses4"}, 64'(rv4_cnt - base4), 64'(1));
    endtask

    task automatic run_window(input string tag, input int gmax);
        longint sum;
        int b0, b4;
        sum = 0;
        for (int i = 0; i < 9; i++) sum += longint'(pix_a[i]) * longint'(wt_a[i]);
        b0 = rv0_cnt;
        b4 = rv4_cnt;
        open_window();
        chk({tag, "_busy_open"}, 64'(busy0), 64'(1));
        feed(9, gmax);
        finish_window(tag, sum, b0, b4);
    endtask

    initial begin
        int b0, b4;

        tick();
        tick();
        chk("rst_busy", 64'(busy0), 64'(0));
        chk("rst_result", 64'(res0), 64'(0));
        chk("rst_rvld", 64'(rvld0), 64'(0));
        chk("rst_result4", 64'(res4), 64'(0));
        rst_n = 1'b1;
        tick();

        fill(1, 1);
        run_window("ones", 0);

        fill(127, 127);
        run_window("satmax", 0);

        fill(-128, 127);
        run_window("satmin", 0);

        fill(10, 10);
        run_window("shift900", 0);

        fill(0, 0);
        pix_a[0] = 3;
        wt_a[0]  = -5;
        run_window("neg15", 0);

        fill(2, 3);
        run_window("gaps", 3);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 9; i++) begin
                pix_a[i] = int'($urandom_range(0, 255)) - 128;
                wt_a[i]  = int'($urandom_range(0, 255)) - 128;
            end
            run_window($sformatf("rand%0d", r), 2);
        end

        // Restart mid-window: only the second window may produce a result.
        b0 = rv0_cnt;
        b4 = rv4_cnt;
        open_window();
        fill(7, 7);
        feed(5, 0);
        start = 1'b1;
        valid = 1'b1;
        pix = 8'd7;
        wt  = 8'd7;
        tick();
        start = 1'b0;
        valid = 1'b0;
        fill(1, 2);
        feed(9, 0);
        finish_window("restart", 18, b0, b4);

        // Asynchronous reset after four taps discards the window.
        b0 = rv0_cnt;
        open_window();
        fill(1, 1);
        feed(4, 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy0), 64'(0));
        chk("midrst_result", 64'(res0), 64'(0));
        chk("midrst_rvld", 64'(rvld0), 64'(0));
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("midrst_no_pulse", 64'(rv0_cnt - b0), 64'(0));
        chk("midrst_busy_after", 64'(busy0), 64'(0));
        chk("midrst_result_after", 64'(res0), 64'(0));

        fill(1, 1);
        run_window("post_rst", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_mac_acc.md
Name: conv_mac_acc

Overview:
- Multiply-accumulate stage that sits directly upstream of the accelerator's output register.
- Consumes a stream of signed pixel/weight pairs for one convolution window (KERNEL_TAPS pairs).
- Accumulates at full precision, then applies an arithmetic right shift for fixed-point scaling and saturates to the output width.
- Emits the result with a one-cycle Result_Valid pulse, which is wired straight to the output register's Set input.

Parameters:
- DATA_WIDTH, 8: signed width of pixel and weight inputs.
- ACC_WIDTH, 24: signed accumulator width; must be >= 2*DATA_WIDTH + clog2(KERNEL_TAPS).
- OUT_WIDTH, 16: signed result width; must match the output register's data width.
- KERNEL_TAPS, 9: number of products per window; must be >= 1.
- FRAC_BITS, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- CONV_MAC_ACC_Clk  in  1  clock; all state updates on its rising edge.
- CONV_MAC_ACC_Reset  in  1  asynchronous, active-low reset.
- CONV_MAC_ACC_Start  in  1  one-cycle pulse that opens a new window.
- CONV_MAC_ACC_Valid_In  in  1  pixel/weight pair is valid this cycle.
- CONV_MAC_ACC_Pixel_In  in  DATA_WIDTH  signed pixel.
- CONV_MAC_ACC_Weight_In  in  DATA_WIDTH  signed weight.
- CONV_MAC_ACC_Busy  out  1  high while in the ACCUM, DRAIN or DONE state.
- CONV_MAC_ACC_Result  out  OUT_WIDTH  signed, saturated, registered result.
- CONV_MAC_ACC_Result_Valid  out  1  one-cycle pulse; drives the output register's Set.

Behaviour:
- Reset (asynchronous, active-low, one clock):
  - State = IDLE; accumulator, tap counter and product register cleared; product-valid flag cleared.
  - Busy = 0, Result = 0, Result_Valid = 0.
  - Reset asserted mid-window discards the window; no Result_Valid is produced.
- FSM states: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - Valid_In is ignored.
  - Start -> ACCUM; clears the accumulator and tap counter.
- ACCUM:
  - Valid_In is ignored in the cycle Start is sampled; the first tap is accepted the cycle after.
  - Each cycle with Valid_In=1 accepts one pair:
    - product register <= Pixel_In * Weight_In (full 2*DATA_WIDTH signed);
    - product-valid flag set for the next cycle;
    - tap counter increments.
  - Gaps (Valid_In=0) are allowed anywhere; the counter holds through them.
  - Any cycle with the product-valid flag set: accumulator <= accumulator + sign-extended product.
  - Accepting tap KERNEL_TAPS-1 (counter == KERNEL_TAPS-1 with Valid_In=1) -> DRAIN.
- DRAIN:
  - Last product is added to the accumulator.
  - Valid_In is ignored -> DONE.
- DONE:
  - Result <= sat(accumulator >>> FRAC_BITS).
  - Result_Valid = 1 for exactly this one registered cycle -> IDLE.
- Latency: last tap accepted at edge k; Result and Result_Valid update at edge k+2; Result_Valid is high for the cycle following edge k+2.
- Result holds its value until the next DONE; it does not change between windows.
- Saturation:
  - Shifted value > 2^(OUT_WIDTH-1)-1 -> clamp to max.
  - Shifted value < -2^(OUT_WIDTH-1) -> clamp to min.
  - Otherwise truncate to OUT_WIDTH; no rounding.
- Start in ACCUM or DRAIN: restart. The accumulator and counter clear, any in-flight product is discarded, state = ACCUM, and no Result_Valid is produced for the aborted window.
- Start in DONE: the DONE output still completes, then the FSM goes to ACCUM instead of IDLE.
- KERNEL_TAPS = 1: the first accepted tap goes straight to DRAIN.

Optional Feature:
- Macro: CONV_MAC_ACC_RELU_EN.
- Defined: a negative saturated result is replaced by 0 before it is registered into Result (ReLU fused ahead of the output register).
- Undefined: signed saturated results pass through unchanged.

Decomposition:
- Shared package conv_pkg:
  - FSM state encoding (2-bit localparams for IDLE, ACCUM, DRAIN, DONE);
  - default width constants (DATA_WIDTH, ACC_WIDTH, OUT_WIDTH);
  - KERNEL_TAPS default.
- One natural sub-module: conv_sat_shift. Purely combinational: arithmetic shift by FRAC_BITS, clamp from ACC_WIDTH to OUT_WIDTH, optional ReLU. It is reused later by the pooling stage.

Test Plan:
- Defaults; Start, then 9 taps of 1*1 back-to-back -> Result=9; Result_Valid high exactly once, 2 edges after the last tap; Busy low afterwards.
- 9 taps of 127*127 -> sum 145161 saturates -> Result=32767. 9 taps of -128*127 -> Result=-32768, or 0 with CONV_MAC_ACC_RELU_EN defined.
- FRAC_BITS=4; 9 taps of 10*10 (sum 900) -> Result=56. Taps 3*(-5) and the remaining 8 taps at 0 (sum -15) -> Result=-1 (arithmetic shift).
- 9 taps of 2*3 with random 0-3 cycle Valid_In gaps, plus Valid_In asserted in IDLE and in the Start cycle -> Result=54; the ignored pairs do not contribute.
- Restart and reset mid-window:
  - Start, 5 taps of 7*7, Start again, then 9 taps of 1*2 -> a single Result_Valid, Result=18.
  - Reset pulsed after 4 taps -> Busy=0, Result=0, no Result_Valid.
